// File: rtl/qs_pkg.sv
// Shared types for the qs sorter datapath and its packet output buffer.
package qs_pkg;

  localparam int unsigned W = 32;

  typedef logic [W-1:0] w_t;

  typedef struct packed {
    logic sop;
    logic eop;
    w_t   dat;
  } qs_pkt_fifo_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DROP   = 2'd2
  } qs_pkt_fifo_state_t;

  // One extra bit over the address so full and empty are distinguishable.
  function automatic int unsigned qs_pkt_fifo_ptr_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/qs_pkt_fifo_ram.sv
// Packet buffer storage: N entries, synchronous write, combinational read.
module qs_pkt_fifo_ram
  import qs_pkg::*;
#(
  parameter int unsigned N  = 64,
  parameter int unsigned AW = $clog2(N)
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  qs_pkt_fifo_entry_t i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output qs_pkt_fifo_entry_t o_rdata
);

  qs_pkt_fifo_entry_t r_mem [N];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/qs_pkt_fifo.sv
// Packet-aware output buffer: commits only whole error-free packets, rewinds
// the write pointer to discard bad ones, and presents words on valid/ready.
module qs_pkt_fifo
  import qs_pkg::*;
#(
  parameter int unsigned N     = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic             in_err,
  input  w_t               in_dat,
  output logic             out_vld_r,
  output logic             out_sop_r,
  output logic             out_eop_r,
  output w_t               out_dat_r,
  input  logic             out_rdy,
  output logic [CNT_W-1:0] drop_cnt_r,
  output logic             busy_r
);

  localparam int unsigned PW = qs_pkt_fifo_ptr_w(N);
  localparam int unsigned AW = PW - 1;
  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t DEPTH = ptr_t'(N);
  localparam ptr_t ONE   = ptr_t'(1);

  qs_pkt_fifo_state_t r_state, w_st_nxt;
  ptr_t               r_wr_ptr, r_cmt_ptr, r_rd_ptr;
  ptr_t               w_wr_nxt, w_cmt_nxt, w_rd_nxt, w_base, w_waddr;
  logic               r_perr, w_perr_nxt, w_err, w_full, w_we, w_pop;
  logic [1:0]         w_ndrop;
  logic [CNT_W:0]     w_sum;
  qs_pkt_fifo_entry_t w_wentry, w_rentry;

  assign w_wentry = '{sop: in_sop, eop: in_eop, dat: in_dat};

  // A sop during ACTIVE abandons the open packet and restarts from cmt_ptr in
  // the same cycle, so fullness and the write address use the rewound base;
  // that cycle can therefore count two drops (abandon plus full).
  always_comb begin
    w_we       = 1'b0;
    w_waddr    = r_wr_ptr;
    w_wr_nxt   = r_wr_ptr;
    w_cmt_nxt  = r_cmt_ptr;
    w_st_nxt   = r_state;
    w_perr_nxt = r_perr;
    w_ndrop    = '0;
    w_base     = r_wr_ptr;
    w_err      = in_err | r_perr;
    w_full     = 1'b0;
    if (in_vld) begin
      if (in_sop) begin
        w_err = in_err;
        if (r_state == ACTIVE) begin
          w_base  = r_cmt_ptr;
          w_ndrop = 2'd1;
        end
      end
      w_full = (w_base - r_rd_ptr) == DEPTH;
      if (in_sop || r_state == ACTIVE) begin
        if (w_full) begin
          w_ndrop  = w_ndrop + 2'd1;
          w_wr_nxt = r_cmt_ptr;
          w_st_nxt = in_eop ? IDLE : DROP;
        end else if (in_eop) begin
          w_st_nxt = IDLE;
          if (w_err) begin
            w_ndrop  = w_ndrop + 2'd1;
            w_wr_nxt = r_cmt_ptr;
          end else begin
            w_we      = 1'b1;
            w_waddr   = w_base;
            w_wr_nxt  = w_base + ONE;
            w_cmt_nxt = w_base + ONE;
          end
        end else begin
          w_we       = 1'b1;
          w_waddr    = w_base;
          w_wr_nxt   = w_base + ONE;
          w_st_nxt   = ACTIVE;
          w_perr_nxt = w_err;
        end
      end else if (r_state == DROP && in_eop) begin
        w_st_nxt = IDLE;
      end
    end
  end

  assign w_pop    = (r_rd_ptr != r_cmt_ptr) && (!out_vld_r || out_rdy);
  assign w_rd_nxt = w_pop ? r_rd_ptr + ONE : r_rd_ptr;
  assign w_sum    = {1'b0, drop_cnt_r} + {{(CNT_W-1){1'b0}}, w_ndrop};

  qs_pkt_fifo_ram #(
    .N (N)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr[AW-1:0]),
    .i_wdata (w_wentry),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rentry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_cmt_ptr  <= '0;
      r_rd_ptr   <= '0;
      r_perr     <= 1'b0;
      out_vld_r  <= 1'b0;
      out_sop_r  <= 1'b0;
      out_eop_r  <= 1'b0;
      out_dat_r  <= '0;
      drop_cnt_r <= '0;
      busy_r     <= 1'b0;
    end else begin
      r_state    <= w_st_nxt;
      r_wr_ptr   <= w_wr_nxt;
      r_cmt_ptr  <= w_cmt_nxt;
      r_rd_ptr   <= w_rd_nxt;
      r_perr     <= w_perr_nxt;
      drop_cnt_r <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
      busy_r     <= (w_st_nxt != IDLE) || (w_cmt_nxt != w_rd_nxt);
      if (w_pop) begin
        out_vld_r <= 1'b1;
        out_sop_r <= w_rentry.sop;
        out_eop_r <= w_rentry.eop;
        out_dat_r <= w_rentry.dat;
      end else if (out_rdy) begin
        out_vld_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qs_pkt_fifo.sv
// Directed plus randomized bench for qs_pkt_fifo against a packet-level queue model.
module tb_qs_pkt_fifo;
  import qs_pkg::*;

  localparam int unsigned N = 8;
  localparam int M_IDLE = 0, M_ACT = 1, M_DROP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_vld = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_err = 1'b0;
  w_t          in_dat = '0;
  logic        out_vld_r, out_sop_r, out_eop_r, out_rdy = 1'b0;
  w_t          out_dat_r;
  logic [15:0] drop_cnt_r;
  logic        busy_r;

  qs_pkt_fifo #(.N(N), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (in_vld),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_err     (in_err),
    .in_dat     (in_dat),
    .out_vld_r  (out_vld_r),
    .out_sop_r  (out_sop_r),
    .out_eop_r  (out_eop_r),
    .out_dat_r  (out_dat_r),
    .out_rdy    (out_rdy),
    .drop_cnt_r (drop_cnt_r),
    .busy_r     (busy_r)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Packet-level model: words of the open packet, committed entries not yet
  // moved into the output register, and the expected output register.
  int                 mst = M_IDLE;
  bit                 perr = 0;
  w_t                 cur[$];
  qs_pkt_fifo_entry_t qc[$];
  bit                 e_vld = 0, e_sop = 0, e_eop = 0;
  w_t                 e_dat = '0;
  int                 e_drop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mst = M_IDLE; perr = 0; cur.delete(); qc.delete();
    e_vld = 0; e_sop = 0; e_eop = 0; e_dat = '0; e_drop = 0;
  endtask

  task automatic model_edge(input bit v, s, e, er, input w_t d, input bit rdy);
    bit popok, full, bad;
    qs_pkt_fifo_entry_t ent;
    popok = (qc.size() != 0) && (!e_vld || rdy);
    if (v) begin
      if (s) begin
        if (mst == M_ACT) begin cur.delete(); e_drop++; end
        mst = M_ACT; perr = 0;
      end
      if (mst == M_ACT) begin
        bad  = er | perr;
        perr = bad;
        full = (qc.size() + cur.size()) == N;
        if (full) begin
          cur.delete(); e_drop++;
          mst = e ? M_IDLE : M_DROP;
        end else begin
          cur.push_back(d);
          if (e) begin
            if (bad) e_drop++;
            else
              for (int i = 0; i < cur.size(); i++)
                qc.push_back('{sop: (i == 0), eop: (i == cur.size() - 1), dat: cur[i]});
            cur.delete();
            mst = M_IDLE;
          end
        end
      end else if (mst == M_DROP && e) begin
        mst = M_IDLE;
      end
    end
    if (popok) begin
      ent = qc.pop_front();
      e_vld = 1; e_sop = ent.sop; e_eop = ent.eop; e_dat = ent.dat;
    end else if (rdy) begin
      e_vld = 0;
    end
  endtask

  task automatic compare_all();
    chk("out_vld", out_vld_r, e_vld);
    chk("drop_cnt", drop_cnt_r, e_drop);
    chk("busy", busy_r, (mst != M_IDLE) || (qc.size() != 0));
    if (e_vld) begin
      chk("out_sop", out_sop_r, e_sop);
      chk("out_eop", out_eop_r, e_eop);
      chk("out_dat", out_dat_r, e_dat);
    end
  endtask

  task automatic step(input bit v, s, e, er, input w_t d, input bit rdy);
    in_vld = v; in_sop = s; in_eop = e; in_err = er; in_dat = d; out_rdy = rdy;
    @(posedge clk);
    model_edge(v, s, e, er, d, rdy);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, rdy);
  endtask

  task automatic hard_reset();
    in_vld = 0; in_sop = 0; in_eop = 0; in_err = 0;
    rst = 1;
    #2;
    model_reset();
    chk("rst_vld", out_vld_r, 0);
    chk("rst_sop", out_sop_r, 0);
    chk("rst_eop", out_eop_r, 0);
    chk("rst_dat", out_dat_r, 0);
    chk("rst_drop", drop_cnt_r, 0);
    chk("rst_busy", busy_r, 0);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    int len;
    bit noeop, rdy;
    bit pat [9] = '{1, 0, 0, 1, 1, 0, 1, 1, 1};

    #2;
    hard_reset();

    // 1: [5,7,9] straight through
    step(1, 1, 0, 0, 5, 1);
    step(1, 0, 0, 0, 7, 1);
    step(1, 0, 1, 0, 9, 1);
    chk("t1_not_yet", out_vld_r, 0);
    step(0, 0, 0, 0, '0, 1);
    chk("t1_w0", out_dat_r, 5);
    chk("t1_w0_sop", out_sop_r, 1);
    step(0, 0, 0, 0, '0, 1);
    chk("t1_w1", out_dat_r, 7);
    step(0, 0, 0, 0, '0, 1);
    chk("t1_w2", out_dat_r, 9);
    chk("t1_w2_eop", out_eop_r, 1);
    idle(2, 1);
    chk("t1_drop", drop_cnt_r, 0);

    // 2: errored packet
    step(1, 1, 0, 1, 1, 1);
    step(1, 0, 1, 0, 2, 1);
    idle(3, 1);
    chk("t2_drop", drop_cnt_r, 1);
    chk("t2_busy", busy_r, 0);

    // 3: overflow with stalled output, then a 4-word packet
    for (int i = 0; i < 10; i++) step(1, i == 0, i == 9, 0, 32'h100 + i, 0);
    for (int i = 0; i < 4; i++) step(1, i == 0, i == 3, 0, 32'hA + i, 0);
    idle(3, 0);
    chk("t3_drop", drop_cnt_r, 2);
    chk("t3_hold_A", out_dat_r, 32'hA);
    idle(6, 1);

    // 4: stalls with two committed packets
    step(1, 1, 0, 0, 1, 0);
    step(1, 0, 1, 0, 2, 0);
    step(1, 1, 1, 0, 3, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, '0, pat[i]);
    idle(3, 1);

    // 5: missing eop, then a good packet
    step(1, 1, 0, 0, 1, 1);
    step(1, 0, 0, 0, 2, 1);
    step(1, 1, 0, 0, 3, 1);
    step(1, 0, 1, 0, 4, 1);
    idle(4, 1);
    chk("t5_drop", drop_cnt_r, 3);

    // 6: reset mid-packet with committed data pending
    step(1, 1, 0, 0, 8, 0);
    step(1, 0, 1, 0, 9, 0);
    step(1, 1, 0, 0, 6, 0);
    hard_reset();
    step(1, 1, 1, 0, 4, 1);
    step(0, 0, 0, 0, '0, 1);
    chk("t6_word", out_dat_r, 4);
    idle(3, 1);
    chk("t6_drop", drop_cnt_r, 0);

    // Randomized packets, gaps, errors, missing eops and stray words
    for (int p = 0; p < 80; p++) begin
      len   = $urandom_range(1, 11);
      noeop = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0)
        step(1, 0, 1'($urandom_range(0, 1)), 0, $urandom, ($urandom_range(0, 3) != 0));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1, ($urandom_range(0, 3) != 0));
        rdy = ($urandom_range(0, 3) != 0);
        step(1, i == 0, (i == len - 1) && !noeop, ($urandom_range(0, 15) == 0), $urandom, rdy);
      end
    end
    idle(20, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qs_pkt_fifo.md
Name: qs_pkt_fifo

Overview:
- Packet-aware output buffer placed directly downstream of the qs sorter.
- Absorbs the sorter's push-only sorted stream (vld/sop/eop/err/dat, no backpressure) and re-presents it on a valid/ready interface.
- Only whole, error-free packets become visible downstream. Errored, malformed or overflowing packets are discarded by rewinding the write pointer, and each discard is counted.

Parameters:
N, 64, buffer depth in words; power of two, >= 4.
CNT_W, 16, width of the saturating drop counter.

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous, active-high.
in_vld  in  1  sorted word valid (driven from qs out_vld_r).
in_sop  in  1  first word of packet.
in_eop  in  1  last word of packet.
in_err  in  1  packet error flag; sticky per packet, checked on every word.
in_dat  in  qs_pkg::W  sorted word.
out_vld_r  out  1  output word valid.
out_sop_r  out  1  output first word.
out_eop_r  out  1  output last word.
out_dat_r  out  qs_pkg::W  output word.
out_rdy  in  1  downstream accepts the word when out_vld_r & out_rdy.
drop_cnt_r  out  CNT_W  count of discarded packets; saturates at all-ones.
busy_r  out  1  write FSM not IDLE, or buffer non-empty.

Behaviour:
- Reset: all outputs 0; all pointers 0; FSM IDLE; stored words are not cleared. Reset mid-packet discards the partial packet and all committed, unread data, and does not increment drop_cnt_r.
- Pointers:
  - wr_ptr, speculative write.
  - cmt_ptr, committed packet boundary.
  - rd_ptr, read.
  - Each is log2(N)+1 bits and wraps naturally.
  - full = (wr_ptr - rd_ptr) == N.
  - Readable when rd_ptr != cmt_ptr.
- Entry: {sop, eop, dat}, stored on every accepted write.
- Write FSM states: IDLE, ACTIVE, DROP. Packet error flag perr is set by in_err and cleared on each new sop.
  - IDLE, in_vld & !in_sop: word ignored, no count.
  - IDLE, in_vld & in_sop & !full: write the word, go to ACTIVE. If in_eop is also set, apply the eop rules below in the same cycle (a single-word packet never enters ACTIVE).
  - ACTIVE, in_vld & !in_sop & !full: write the word.
  - ACTIVE, in_vld & in_sop: treat as an abandoned packet. Set wr_ptr = cmt_ptr, drop_cnt++, then process the word as a new sop from IDLE in the same cycle.
  - Any state, in_vld & full while a packet is being written: set wr_ptr = cmt_ptr, drop_cnt++, go to DROP. If the word also has eop, go to IDLE instead.
  - DROP: ignore words until eop, then go to IDLE. A sop arriving in DROP is accepted as a new packet.
  - eop with (in_err | perr): set wr_ptr = cmt_ptr, drop_cnt++, go to IDLE.
  - eop without error: write the word, set cmt_ptr = wr_ptr+1, go to IDLE.
- A packet longer than N words is always dropped.
- Read side, registered output stage:
  - pop = (rd_ptr != cmt_ptr) & (!out_vld_r | out_rdy).
  - On pop: out_* loads the entry at rd_ptr and rd_ptr increments.
  - Otherwise, if out_rdy: out_vld_r clears.
  - While out_vld_r & !out_rdy, all out_* fields hold stable.
- Latency: eop accepted at edge T commits at T; the packet's sop word appears on out_* at edge T+1. Full throughput is one word per cycle.
- Simultaneous read/write: always legal. The reader never passes cmt_ptr, so there is no read-after-write hazard. full is computed from rd_ptr before the current pop.
- drop_cnt_r saturates and never wraps.

Decomposition:
- Add to qs_pkg:
  - qs_pkt_fifo_entry_t struct {sop, eop, w_t dat}.
  - qs_pkt_fifo_state_t enum {IDLE, ACTIVE, DROP}.
  - Pointer-width function of N.
- One sub-module, qs_pkt_fifo_ram: N x entry flop array, one synchronous write port and one combinational read port.
- FSM, pointers and output stage stay in qs_pkt_fifo.

Test Plan (N=8, W=32):
1. Packet [5,7,9], out_rdy=1, no err -> sop word appears at edge T+1 after the eop edge; output 5(sop),7,9(eop) on consecutive cycles; drop_cnt_r=0.
2. Packet [1,2] with in_err=1 on word 1 only -> no output; drop_cnt_r=1; busy_r returns to 0.
3. out_rdy=0; 10-word packet then 4-word packet [A,B,C,D] -> first packet dropped, drop_cnt_r=1. Raise out_rdy -> only A..D output, with sop on A and eop on D.
4. Two committed packets [1,2],[3]; out_rdy toggles 1,0,0,1,... -> each word held stable while stalled; order 1,2,3 preserved; out_sop_r/out_eop_r correct.
5. [1,2] with no eop, then sop 3, eop 4 -> output [3(sop),4(eop)] only; drop_cnt_r=1.
6. Commit [8,9], then start [6,...] and assert rst for 1 cycle mid-packet -> all outputs 0 immediately. A following packet [4] is output alone; drop_cnt_r=0.
